alu_cmd_sequencer: RTL and testbench
====================================

Name: alu_cmd_sequencer

Overview:
Command front-end for alu_top. It accepts ALU commands over a valid/ready interface and buffers them in a small FIFO. Commands issue to alu_top one at a time with a one-cycle start pulse. Each result is captured on alu_done and returned over a valid/ready response interface with tag and error status. DIV by zero is trapped locally and never issued.

Parameters:
CMD_DEPTH, 4, command FIFO entries; power of 2, minimum 2
TAG_W, 4, width of the caller tag carried from command to response
TIMEOUT_CYCLES, 64, WAIT-state cycle limit; used only when ALU_TIMEOUT_EN is defined

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  FIFO can accept (= !fifo_full)
cmd_op  in  2  00 ADD, 01 SUB, 10 MUL, 11 DIV
cmd_a  in  8  operand A
cmd_b  in  8  operand B
cmd_tag  in  TAG_W  caller tag
alu_start  out  1  one-cycle start pulse to alu_top
alu_op_code  out  2  op to alu_top
alu_operand_A  out  8  operand A to alu_top
alu_operand_B  out  8  operand B to alu_top
alu_result  in  16  alu_top result; DIV = {remainder, quotient}
alu_done  in  1  alu_top completion
rsp_valid  out  1  response held
rsp_ready  in  1  consumer accepts response
rsp_result  out  16  captured result
rsp_op  out  2  op of this response
rsp_tag  out  TAG_W  tag of this response
rsp_err  out  1  1 = DIV by zero (or timeout, if enabled)

Behaviour:
- Clocking and reset: one clock, clk. reset is synchronous and active-high.
- On reset: FIFO emptied (cmd_ready=1 the next cycle), FSM goes to IDLE, and all outputs are 0.
- Reset mid-operation drops the in-flight command and any held response. No alu_start pulse follows. alu_top shares the reset.
- FIFO push: occurs when cmd_valid && cmd_ready. There is no bypass; an entry is visible to the FSM one cycle after the push.
- FIFO push+pop in the same cycle: both take effect and the count is unchanged.
- FIFO full: cmd_ready=0, and push is ignored even if a pop occurs in that cycle.
- FIFO empty: no pop occurs.
- Pointers wrap modulo CMD_DEPTH. An explicit count of width log2(CMD_DEPTH)+1 distinguishes full from empty.
- Head register (op, a, b, tag) is loaded on pop. It drives alu_op_code/alu_operand_A/alu_operand_B from ISSUE through WAIT, and these stay stable until RESP exits.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if the FIFO is not empty, pop into the head register. If op==11 and b==0, set result=16'hFFFF, err=1, and go to RESP. Otherwise go to ISSUE.
- ISSUE: alu_start=1 for exactly this cycle, then go to WAIT.
- WAIT: alu_done is sampled only in this state. On alu_done=1, capture alu_result into rsp_result, set err=0, and go to RESP. Otherwise stay.
- RESP: rsp_valid=1, and rsp_result/op/tag/err are held stable. On rsp_ready=1, go to IDLE, with rsp_valid=0 the next cycle.
- rsp_valid never drops without a handshake, and only one command is ever in flight.
- Latency with the command accepted at cycle 0 into an empty FIFO and idle FSM:
  - pop in cycle 1
  - alu_start in cycle 2
  - rsp_valid from the cycle after the first alu_done cycle
  - DIV-by-zero: rsp_valid from cycle 2, and alu_start is never asserted
- Back-to-back: after a RESP handshake, IDLE takes one cycle before the next pop.
- Total capacity is CMD_DEPTH buffered commands plus 1 in the head register.

Optional Feature:
ALU_TIMEOUT_EN.
- Defined: an 8+ bit counter clears on entry to WAIT and increments each WAIT cycle without alu_done. When it reaches TIMEOUT_CYCLES, the FSM goes to RESP with rsp_result=16'h0000 and rsp_err=1. If alu_done and the limit coincide, alu_done wins (err=0).
- Not defined: no counter is present, WAIT is unbounded, and rsp_err indicates DIV-by-zero only.

Test Plan:
- ADD a=15 b=10 tag=1, rsp_ready=1 -> one alu_start pulse; rsp_result=16'h0019, rsp_op=00, rsp_tag=1, rsp_err=0.
- SUB 25-10 then MUL 5*6 back-to-back -> responses in order: 16'h000F, then 16'h001E. Exactly one alu_start per command, and operands stable while in WAIT.
- DIV a=40 b=6 -> rsp_result=16'h0406 (remainder 4, quotient 6), rsp_err=0.
- DIV a=40 b=0 -> alu_start stays 0, rsp_result=16'hFFFF, rsp_err=1, rsp_valid in cycle 2 after acceptance.
- rsp_ready=0, stream 6 ADD commands -> 5 accepted (1 in head, 4 in FIFO), cmd_ready=0 on the 6th. Release rsp_ready -> 5 responses in tag order, then cmd_ready=1.
- Reset asserted for 1 cycle while in WAIT -> next cycle rsp_valid=0, alu_start=0, cmd_ready=1. A later stale alu_done produces no response. With ALU_TIMEOUT_EN, holding alu_done=0 for 64 WAIT cycles -> rsp_err=1, rsp_result=0.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// Command front-end for alu_top: FIFO-buffered ALU commands, one in flight, tagged responses.
// Optional WAIT-state timeout is compiled in when ALU_TIMEOUT_EN is defined.
//
// state  | meaning
// IDLE   | waiting for a buffered command; pops it into the head register
// ISSUE  | one-cycle alu_start pulse
// WAIT   | waiting for alu_done (or timeout)
// RESP   | response held until rsp_ready
module alu_cmd_sequencer #(
    parameter int CMD_DEPTH      = 4,
    parameter int TAG_W          = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [7:0]       cmd_a,
    input  logic [7:0]       cmd_b,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic             alu_start,
    output logic [1:0]       alu_op_code,
    output logic [7:0]       alu_operand_A,
    output logic [7:0]       alu_operand_B,
    input  logic [15:0]      alu_result,
    input  logic             alu_done,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [15:0]      rsp_result,
    output logic [1:0]       rsp_op,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_err
);

    localparam int PTR_W = $clog2(CMD_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CMD_DEPTH);

    typedef struct packed {
        logic [1:0]       op;
        logic [7:0]       a;
        logic [7:0]       b;
        logic [TAG_W-1:0] tag;
    } cmd_t;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    cmd_t             mem_q [CMD_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    cmd_t             head_q;
    cmd_t             fifo_out;
    logic [15:0]      res_q;
    logic             err_q;
    state_t           state_q, state_d;
    logic             push, pop, head_div0, tmo_hit;

    assign cmd_ready = (count_q != FULL_CNT);
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state_q == S_IDLE) && (count_q != '0);
    assign fifo_out  = mem_q[rd_ptr_q];
    assign head_div0 = (fifo_out.op == 2'b11) && (fifo_out.b == 8'h00);

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{op: cmd_op, a: cmd_a, b: cmd_b, tag: cmd_tag};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

`ifdef ALU_TIMEOUT_EN
    localparam int TMO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [TMO_W-1:0] tmo_cnt_q;

    // Hit on the last permitted WAIT cycle; a coincident alu_done takes priority.
    assign tmo_hit = (state_q == S_WAIT) && !alu_done &&
                     (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset || state_q == S_ISSUE) begin
            tmo_cnt_q <= '0;
        end else if (state_q == S_WAIT && !alu_done) begin
            tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
        end
    end
`else
    localparam int unused_tmo_cycles = TIMEOUT_CYCLES;
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (pop) state_d = head_div0 ? S_RESP : S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  if (alu_done || tmo_hit) state_d = S_RESP;
            S_RESP:  if (rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        alu_start = (state_q == S_ISSUE);
        rsp_valid = (state_q == S_RESP);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q <= '0;
            res_q  <= '0;
            err_q  <= 1'b0;
        end else if (pop) begin
            head_q <= fifo_out;
            if (head_div0) begin
                res_q <= 16'hFFFF;
                err_q <= 1'b1;
            end
        end else if (state_q == S_WAIT && alu_done) begin
            res_q <= alu_result;
            err_q <= 1'b0;
        end else if (tmo_hit) begin
            res_q <= 16'h0000;
            err_q <= 1'b1;
        end
    end

    assign alu_op_code   = head_q.op;
    assign alu_operand_A = head_q.a;
    assign alu_operand_B = head_q.b;
    assign rsp_result    = res_q;
    assign rsp_op        = head_q.op;
    assign rsp_tag       = head_q.tag;
    assign rsp_err       = err_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: directed latency/capacity/reset steps plus randomized traffic
// against a queue-based reference and a behavioural alu_top with random latency.
module tb_alu_cmd_sequencer;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [7:0]       cmd_a;
    logic [7:0]       cmd_b;
    logic [TAG_W-1:0] cmd_tag;
    logic             alu_start;
    logic [1:0]       alu_op_code;
    logic [7:0]       alu_operand_A;
    logic [7:0]       alu_operand_B;
    logic [15:0]      alu_result = 16'h0000;
    logic             alu_done = 1'b0;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [15:0]      rsp_result;
    logic [1:0]       rsp_op;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_err;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(.CMD_DEPTH(4), .TAG_W(TAG_W), .TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
        .alu_start(alu_start), .alu_op_code(alu_op_code),
        .alu_operand_A(alu_operand_A), .alu_operand_B(alu_operand_B),
        .alu_result(alu_result), .alu_done(alu_done),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_op(rsp_op), .rsp_tag(rsp_tag), .rsp_err(rsp_err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // {err, result} for a command, straight from the op definitions.
    function automatic logic [16:0] ref_rsp(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] wa, wb;
        wa = {8'h00, a};
        wb = {8'h00, b};
        case (op)
            2'b00:   return {1'b0, wa + wb};
            2'b01:   return {1'b0, wa - wb};
            2'b10:   return {1'b0, wa * wb};
            default: begin
                if (b == 8'h00) return {1'b1, 16'hFFFF};
                return {1'b0, a % b, a / b};
            end
        endcase
    endfunction

    typedef struct packed {
        logic [15:0]      res;
        logic [1:0]       op;
        logic [TAG_W-1:0] tag;
        logic             err;
    } exp_t;
    exp_t exp_q[$];

    // Behavioural alu_top: random 1..5 cycle latency, checks operand stability while busy.
    logic       alu_hold = 1'b0;
    logic       inject_done = 1'b0;
    int         starts = 0;
    logic       busy = 1'b0;
    int         lat = 0;
    logic [1:0] m_op = 2'b00;
    logic [7:0] m_a = 8'h00;
    logic [7:0] m_b = 8'h00;

    always @(posedge clk) if (alu_start === 1'b1) starts++;

    always @(negedge clk) begin
        logic [16:0] r;
        alu_done = 1'b0;
        if (reset) begin
            busy = 1'b0;
        end else if (alu_start) begin
            busy = 1'b1;
            lat  = $urandom_range(0, 4);
            m_op = alu_op_code;
            m_a  = alu_operand_A;
            m_b  = alu_operand_B;
        end else if (busy) begin
            check("wait_op_stable", {30'd0, alu_op_code}, {30'd0, m_op});
            check("wait_a_stable", {24'd0, alu_operand_A}, {24'd0, m_a});
            check("wait_b_stable", {24'd0, alu_operand_B}, {24'd0, m_b});
            if (!alu_hold) begin
                if (lat == 0) begin
                    r          = ref_rsp(m_op, m_a, m_b);
                    alu_result = r[15:0];
                    alu_done   = 1'b1;
                    busy       = 1'b0;
                end else begin
                    lat--;
                end
            end
        end
        if (inject_done) begin
            alu_done   = 1'b1;
            alu_result = 16'hBEEF;
        end
    end

    task automatic push_cmd(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                            input logic [TAG_W-1:0] tag, input logic [15:0] res, input logic err);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_tag   = tag;
        check("push_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        if (cmd_ready) exp_q.push_back('{res, op, tag, err});
    endtask

    task automatic check_rsp(input exp_t e);
        check("rsp_result", {16'd0, rsp_result}, {16'd0, e.res});
        check("rsp_op", {30'd0, rsp_op}, {30'd0, e.op});
        check("rsp_tag", {28'd0, rsp_tag}, {28'd0, e.tag});
        check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
    endtask

    task automatic drain(input int budget);
        int cyc = 0;
        exp_t e;
        rsp_ready = 1'b1;
        while (exp_q.size() > 0 && cyc < budget) begin
            if (rsp_valid) begin
                e = exp_q.pop_front();
                check_rsp(e);
            end
            @(negedge clk);
            cyc++;
        end
        check("drain_outstanding", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic run_random(input int n);
        int          sent = 0;
        int          got = 0;
        int          cyc = 0;
        bit          clr = 1'b0;
        bit          held = 1'b0;
        logic [15:0] held_res = 16'h0000;
        logic [16:0] r;
        exp_t        e;
        cmd_valid = 1'b0;
        while (got < n && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            if (held) begin
                check("rsp_hold_valid", {31'd0, rsp_valid}, 32'd1);
                check("rsp_hold_result", {16'd0, rsp_result}, {16'd0, held_res});
            end
            held = 1'b0;
            rsp_ready = ($urandom_range(0, 99) < 60);
            if (rsp_valid) begin
                if (rsp_ready) begin
                    check("rsp_expected", exp_q.size() > 0, 32'd1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check_rsp(e);
                    end
                    got++;
                end else begin
                    held     = 1'b1;
                    held_res = rsp_result;
                end
            end
            if (clr) begin
                cmd_valid = 1'b0;
                clr = 1'b0;
            end
            if (!cmd_valid && sent < n && $urandom_range(0, 99) < 70) begin
                cmd_op    = 2'($urandom_range(0, 3));
                cmd_a     = 8'($urandom);
                cmd_b     = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
                cmd_tag   = TAG_W'($urandom);
                cmd_valid = 1'b1;
            end
            if (cmd_valid && cmd_ready) begin
                r = ref_rsp(cmd_op, cmd_a, cmd_b);
                exp_q.push_back('{r[15:0], cmd_op, cmd_tag, r[16]});
                sent++;
                clr = 1'b1;
            end
        end
        cmd_valid = 1'b0;
        check("random_rsp_count", got, n);
        exp_q.delete();
    endtask

    initial begin
        int s0;
        int s1;
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_a = 8'h00; cmd_b = 8'h00;
        cmd_tag = '0; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset_alu_start", {31'd0, alu_start}, 32'd0);
        check("reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("reset_rsp_result", {16'd0, rsp_result}, 32'd0);
        check("reset_alu_a", {24'd0, alu_operand_A}, 32'd0);
        reset = 1'b0;

        // ADD 15+10, cycle-accurate start pulse
        rsp_ready = 1'b1;
        s0 = starts;
        push_cmd(2'b00, 8'd15, 8'd10, 4'd1, 16'h0019, 1'b0);
        @(negedge clk); cmd_valid = 1'b0;
        check("add_c1_start", {31'd0, alu_start}, 32'd0);
        @(negedge clk);
        check("add_c2_start", {31'd0, alu_start}, 32'd1);
        check("add_c2_a", {24'd0, alu_operand_A}, 32'd15);
        @(negedge clk);
        check("add_c3_start", {31'd0, alu_start}, 32'd0);
        drain(50);
        check("add_start_count", starts - s0, 1);

        // SUB then MUL back-to-back
        s0 = starts;
        push_cmd(2'b01, 8'd25, 8'd10, 4'd2, 16'h000F, 1'b0);
        push_cmd(2'b10, 8'd5, 8'd6, 4'd3, 16'h001E, 1'b0);
        @(negedge clk); cmd_valid = 1'b0;
        drain(100);
        check("submul_start_count", starts - s0, 2);

        // DIV 40/6
        push_cmd(2'b11, 8'd40, 8'd6, 4'd4, 16'h0406, 1'b0);
        @(negedge clk); cmd_valid = 1'b0;
        drain(50);

        // DIV by zero: response in cycle 2, never issued
        s0 = starts;
        push_cmd(2'b11, 8'd40, 8'd0, 4'd5, 16'hFFFF, 1'b1);
        @(negedge clk); cmd_valid = 1'b0;
        check("div0_c1_valid", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        check("div0_c2_valid", {31'd0, rsp_valid}, 32'd1);
        check("div0_c2_start", {31'd0, alu_start}, 32'd0);
        drain(50);
        check("div0_start_count", starts - s0, 0);

        // Capacity: 5 accepted with the response stalled
        rsp_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            logic [16:0] r;
            @(negedge clk);
            cmd_valid = 1'b1;
            cmd_op    = 2'b00;
            cmd_a     = 8'($urandom);
            cmd_b     = 8'($urandom);
            cmd_tag   = TAG_W'(i);
            check("full_cmd_ready", {31'd0, cmd_ready}, (i < 5) ? 32'd1 : 32'd0);
            if (cmd_ready) begin
                r = ref_rsp(cmd_op, cmd_a, cmd_b);
                exp_q.push_back('{r[15:0], cmd_op, cmd_tag, r[16]});
            end
        end
        repeat (3) begin
            @(negedge clk);
            check("full_hold_ready", {31'd0, cmd_ready}, 32'd0);
        end
        cmd_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("full_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("full_queued", exp_q.size(), 5);
        drain(200);
        @(negedge clk);
        check("full_after_ready", {31'd0, cmd_ready}, 32'd1);

        // Reset while in WAIT
        rsp_ready = 1'b1;
        alu_hold  = 1'b1;
        s0 = starts;
        push_cmd(2'b00, 8'd1, 8'd2, 4'd7, 16'h0003, 1'b0);
        @(negedge clk); cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_wait_started", starts - s0, 1);
        check("rst_wait_valid", {31'd0, rsp_valid}, 32'd0);
        #1 reset = 1'b1;
        @(negedge clk);
        #1 reset = 1'b0;
        exp_q.delete();
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_alu_start", {31'd0, alu_start}, 32'd0);
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_alu_a", {24'd0, alu_operand_A}, 32'd0);
        alu_hold    = 1'b0;
        s1          = starts;
        inject_done = 1'b1;
        repeat (2) @(negedge clk);
        inject_done = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("stale_done_valid", {31'd0, rsp_valid}, 32'd0);
        end
        check("stale_done_starts", starts - s1, 0);

        run_random(40);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
